// File: rtl/csel_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
// Holds the default geometry and the segment-count helper.
package csel_pkg;

    localparam int CSEL_WIDTH = 16;
    localparam int CSEL_BLOCK = 4;

    function automatic int seg_count(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/csel_seg.sv
// One carry-select segment: BLOCK-bit dual ripple adder.
// Ports: i_a/i_b segment operands; o_sum0/o_c0 and o_sum1/o_c1 are the
// sum/carry-out for carry-in 0 and 1; o_cm0/o_cm1 carry into the MSB.
module csel_seg
    import csel_pkg::*;
#(
    parameter int BLOCK = CSEL_BLOCK
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    output logic [BLOCK-1:0] o_sum0,
    output logic [BLOCK-1:0] o_sum1,
    output logic             o_c0,
    output logic             o_c1,
    output logic             o_cm0,
    output logic             o_cm1
);

    logic [BLOCK:0] w_r0;
    logic [BLOCK:0] w_r1;

    always_comb begin
        w_r0    = '0;
        w_r1    = '0;
        o_sum0  = '0;
        o_sum1  = '0;
        w_r1[0] = 1'b1;
        for (int k = 0; k < BLOCK; k++) begin
            o_sum0[k]  = i_a[k] ^ i_b[k] ^ w_r0[k];
            o_sum1[k]  = i_a[k] ^ i_b[k] ^ w_r1[k];
            w_r0[k+1]  = (i_a[k] & i_b[k]) | ((i_a[k] ^ i_b[k]) & w_r0[k]);
            w_r1[k+1]  = (i_a[k] & i_b[k]) | ((i_a[k] ^ i_b[k]) & w_r1[k]);
        end
    end

    assign o_c0  = w_r0[BLOCK];
    assign o_c1  = w_r1[BLOCK];
    assign o_cm0 = w_r0[BLOCK-1];
    assign o_cm1 = w_r1[BLOCK-1];

endmodule

// File: rtl/pipe_csel_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready.
// Ports: clk, rst_n (async low); in_valid/in_ready, a, b, cin, sub in;
// out_valid/out_ready, sum, cout (1 = no borrow on sub), ovf out.
module pipe_csel_adder
    import csel_pkg::*;
#(
    parameter int WIDTH = CSEL_WIDTH,
    parameter int BLOCK = CSEL_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = seg_count(WIDTH, BLOCK);

    if (BLOCK < 2 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("pipe_csel_adder: WIDTH must be a multiple of BLOCK >= 2");
    end

    // ---- S1: conditional segment sums ----
    logic [WIDTH-1:0]            w_b_eff;
    logic                        w_c_eff;
    logic [NSEG-1:0][BLOCK-1:0]  w_sum0;
    logic [NSEG-1:0][BLOCK-1:0]  w_sum1;
    logic [NSEG-1:0]             w_c0;
    logic [NSEG-1:0]             w_c1;
    logic                        w_cm0;
    logic                        w_cm1;

    assign w_b_eff = sub ? ~b : b;
    assign w_c_eff = sub | cin;

    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        if (i == NSEG - 1) begin : g_top
            csel_seg #(.BLOCK(BLOCK)) u_seg (
                .i_a    (a[i*BLOCK +: BLOCK]),
                .i_b    (w_b_eff[i*BLOCK +: BLOCK]),
                .o_sum0 (w_sum0[i]),
                .o_sum1 (w_sum1[i]),
                .o_c0   (w_c0[i]),
                .o_c1   (w_c1[i]),
                .o_cm0  (w_cm0),
                .o_cm1  (w_cm1)
            );
        end else begin : g_low
            // Only the top segment's MSB carry matters for overflow.
            logic w_unused_cm0;
            logic w_unused_cm1;
            csel_seg #(.BLOCK(BLOCK)) u_seg (
                .i_a    (a[i*BLOCK +: BLOCK]),
                .i_b    (w_b_eff[i*BLOCK +: BLOCK]),
                .o_sum0 (w_sum0[i]),
                .o_sum1 (w_sum1[i]),
                .o_c0   (w_c0[i]),
                .o_c1   (w_c1[i]),
                .o_cm0  (w_unused_cm0),
                .o_cm1  (w_unused_cm1)
            );
        end
    end

    logic                        r_s1_valid;
    logic [NSEG-1:0][BLOCK-1:0]  r_s1_sum0;
    logic [NSEG-1:0][BLOCK-1:0]  r_s1_sum1;
    logic [NSEG-1:0]             r_s1_c0;
    logic [NSEG-1:0]             r_s1_c1;
    logic                        r_s1_cm0;
    logic                        r_s1_cm1;
    logic                        r_s1_cin;

    logic                        r_s2_valid;
    logic [WIDTH-1:0]            r_sum;
    logic                        r_cout;
    logic                        r_ovf;

    // Backpressure: a stage may load when empty or when it drains.
    logic w_s2_load;
    logic w_s1_load;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum0  <= '0;
            r_s1_sum1  <= '0;
            r_s1_c0    <= '0;
            r_s1_c1    <= '0;
            r_s1_cm0   <= 1'b0;
            r_s1_cm1   <= 1'b0;
            r_s1_cin   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sum0 <= w_sum0;
                r_s1_sum1 <= w_sum1;
                r_s1_c0   <= w_c0;
                r_s1_c1   <= w_c1;
                r_s1_cm0  <= w_cm0;
                r_s1_cm1  <= w_cm1;
                r_s1_cin  <= w_c_eff;
            end
        end
    end

    // ---- S2: ripple the select chain from the effective carry-in ----
    logic [NSEG:0]               w_car;
    logic [NSEG-1:0][BLOCK-1:0]  w_sel;
    logic                        w_cmsb;

    always_comb begin
        w_car    = '0;
        w_sel    = '0;
        w_car[0] = r_s1_cin;
        for (int i = 0; i < NSEG; i++) begin
            w_sel[i]   = w_car[i] ? r_s1_sum1[i] : r_s1_sum0[i];
            w_car[i+1] = w_car[i] ? r_s1_c1[i] : r_s1_c0[i];
        end
        w_cmsb = w_car[NSEG-1] ? r_s1_cm1 : r_s1_cm0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sel;
                r_cout <= w_car[NSEG];
                r_ovf  <= w_cmsb ^ w_car[NSEG];
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Bench for pipe_csel_adder (WIDTH=16, BLOCK=4).
// Arithmetic model plus scoreboard, with directed literal vectors.
module tb_pipe_csel_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rx  = 0;
    logic [17:0] q[$];
    logic        held_v = 1'b0;
    logic [17:0] held;
    logic        done;

    always #5 clk = ~clk;

    pipe_csel_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Result = {sum, cout, ovf} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic ci,
                                          input logic sb);
        logic [15:0] ye;
        logic [16:0] t;
        logic        v;
        ye = sb ? ~y : y;
        t  = {1'b0, x} + {1'b0, ye} + {16'd0, (sb | ci)};
        v  = (x[15] == ye[15]) && (t[15] != x[15]);
        return {t[15:0], t[16], v};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (held_v && out_valid) begin
                chk("held_sum", 32'(sum), 32'(held[17:2]));
                chk("held_flags", {30'd0, cout, ovf}, {30'd0, held[1:0]});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 32'(sum), 32'hDEAD_BEEF);
                end else begin
                    logic [17:0] e;
                    e = q.pop_front();
                    chk("sb_sum", 32'(sum), 32'(e[17:2]));
                    chk("sb_cout", 32'(cout), 32'(e[1]));
                    chk("sb_ovf", 32'(ovf), 32'(e[0]));
                end
                n_rx++;
            end
            if (in_valid && in_ready)
                q.push_back(model(a, b, cin, sub));
            held_v = out_valid && !out_ready;
            held   = {sum, cout, ovf};
        end else begin
            held_v = 1'b0;
        end
    end

    // Offer a beat and hold it until accepted (bounded).
    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic sb);
        logic acc;
        int   budget;
        in_valid = 1'b1;
        a = x; b = y; cin = ci; sub = sb;
        acc = 1'b0;
        budget = 50;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Single beat on an empty pipe: result visible two edges later.
    task automatic one_beat(input string nm, input logic [15:0] x,
                            input logic [15:0] y, input logic ci,
                            input logic sb, input logic [15:0] es,
                            input logic ec, input logic eo);
        in_valid = 1'b1;
        a = x; b = y; cin = ci; sub = sb;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({nm, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    logic [15:0] tv_a[8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F,
                             16'hAAAA, 16'h0000, 16'h7FFF, 16'h8001};
    logic [15:0] tv_b[8] = '{16'h4321, 16'hFFFF, 16'h8000, 16'hF0F1,
                             16'h5555, 16'h0001, 16'hFFFF, 16'h0002};
    logic [1:0]  tv_m[8] = '{2'b00, 2'b01, 2'b00, 2'b00,
                             2'b01, 2'b10, 2'b10, 2'b10};

    initial begin
        int rx0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; done = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", {30'd0, cout, ovf}, 32'd0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        one_beat("v1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        one_beat("v2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        one_beat("v3", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        one_beat("v4", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        one_beat("v5", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        one_beat("v6", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-to-back directed table, no backpressure.
        for (int i = 0; i < 8; i++)
            send(tv_a[i], tv_b[i], tv_m[i][0], tv_m[i][1]);
        in_valid = 1'b0;
        drain();

        // Six-beat stream with a three-cycle stall mid-stream.
        rx0 = n_rx;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(16'h1000 * 16'(i + 1) + 16'h0111,
                         16'h0F00 + 16'(i), 1'(i), 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk); @(posedge clk); @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", 32'(n_rx - rx0), 32'd6);

        // Pseudo-random operands under random backpressure.
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(16'($urandom), 16'($urandom),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Fill both stages, then reset between clock edges.
        out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0, 1'b0);
        send(16'h0303, 16'h0101, 1'b0, 1'b1);
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sum", 32'(sum), 32'd0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        one_beat("v7", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
